// File: rtl/uart_tx_byte.sv
// UART byte serializer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits,
// followed by a one-cycle done pulse for the upstream TX manager.
module uart_tx_byte #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TxEn,
  input  logic [7:0] Tx_Dat,
  output logic       Tx_Done_sig,
  output logic       TXD,
  output logic       Busy
);

  localparam int unsigned BIT_CNT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IDX_W   = 3;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR   = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  // Reject parameter sets the counters and FSM cannot represent
  if (BIT_CNT < 4) begin : g_bit_cnt_low
    $error("uart_tx_byte: bit period must be at least 4 clocks");
  end
  if (BIT_CNT > 65536) begin : g_bit_cnt_high
    $error("uart_tx_byte: bit period does not fit the 16-bit baud counter");
  end
  if (PARITY > 2) begin : g_parity_bad
    $error("uart_tx_byte: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_bad
    $error("uart_tx_byte: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               txd_q, txd_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               bit_end;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state plus next registered line level, derived from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = 1'b1;
    done_d  = 1'b0;
    busy_d  = 1'b1;
    bit_end = (cnt_q == CNT_LAST);

    if (state_q != S_IDLE && state_q != S_DONE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (TxEn) begin
          shift_d = Tx_Dat;
          par_d   = (^Tx_Dat) ^ ODD_PAR;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_START:  txd_d  = 1'b0;
      S_DATA:   txd_d  = shift_d[0];
      S_PARITY: txd_d  = par_d;
      S_DONE:   done_d = 1'b1;
      default:  txd_d  = 1'b1;
    endcase
  end

  assign TXD         = txd_q;
  assign Tx_Done_sig = done_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte: three configurations (8N1, 8E2, 8O1) at 10 clocks per bit,
// each checked every cycle against a frame-level model of the line.
module tb_uart_tx_byte;

  localparam int NCH = 3;
  localparam int B   = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       txen  [NCH];
  logic [7:0] txdat [NCH];
  logic       txd   [NCH];
  logic       done  [NCH];
  logic       busy  [NCH];

  int errors = 0;
  int checks = 0;

  uart_tx_byte #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_ch0 (
    .CLK(clk), .RSTn(rst_n), .TxEn(txen[0]), .Tx_Dat(txdat[0]),
    .Tx_Done_sig(done[0]), .TXD(txd[0]), .Busy(busy[0]));
  uart_tx_byte #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(2)) u_ch1 (
    .CLK(clk), .RSTn(rst_n), .TxEn(txen[1]), .Tx_Dat(txdat[1]),
    .Tx_Done_sig(done[1]), .TXD(txd[1]), .Busy(busy[1]));
  uart_tx_byte #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_ch2 (
    .CLK(clk), .RSTn(rst_n), .TxEn(txen[2]), .Tx_Dat(txdat[2]),
    .Tx_Done_sig(done[2]), .TXD(txd[2]), .Busy(busy[2]));

  always #5 clk = ~clk;

  function automatic int par_of(input int ch);
    case (ch)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int ch);
    return (ch == 1) ? 2 : 1;
  endfunction

  function automatic int nbits(input int ch);
    return 9 + ((par_of(ch) != 0) ? 1 : 0) + stop_of(ch);
  endfunction

  function automatic int done_cyc(input int ch);
    return nbits(ch) * B + 1;
  endfunction

  // Level of frame bit i for byte b
  function automatic logic frame_bit(input int ch, input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (par_of(ch) != 0 && i == 9) return (par_of(ch) == 2) ? (^b) : ~(^b);
    return 1'b1;
  endfunction

  // Model: k = cycles since the accepting edge (0 = idle)
  int         k   [NCH] = '{default: 0};
  logic [7:0] lat [NCH] = '{default: 8'h00};

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        k[c] <= 0;
      end else if (k[c] == 0) begin
        if (txen[c]) begin
          k[c]   <= 1;
          lat[c] <= txdat[c];
        end
      end else if (k[c] == done_cyc(c)) begin
        k[c] <= 0;
      end else begin
        k[c] <= k[c] + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [2:0] e, a;
    for (int c = 0; c < NCH; c++) begin
      if (k[c] == 0)                e = 3'b100;
      else if (k[c] == done_cyc(c)) e = 3'b111;
      else                          e = {frame_bit(c, lat[c], (k[c] - 1) / B), 1'b0, 1'b1};
      a = {txd[c], done[c], busy[c]};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL line ch%0d k=%0d txd/done/busy got %b expected %b", c, k[c], a, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame whose accepting edge is the next posedge; bits and done cycle given as literals
  task automatic directed(input int ch, input logic [11:0] exp_bits, input int done_at);
    int seen;
    int at;
    int bi;
    seen = 0;
    at   = 0;
    @(posedge clk);
    for (int c = 1; c <= done_at; c++) begin
      @(negedge clk);
      bi = (c - 1) / B;
      if ((c - 1) % B == B / 2 && bi < (done_at - 1) / B)
        check($sformatf("ch%0d bit%0d", ch, bi), 32'(txd[ch]), 32'(exp_bits[bi]));
      if (done[ch]) begin
        seen++;
        at = c;
      end
    end
    check($sformatf("ch%0d done count", ch), 32'(seen), 32'd1);
    check($sformatf("ch%0d done cycle", ch), 32'(at), 32'(done_at));
    @(posedge clk);
    #1 txen[ch] = 1'b0;
  endtask

  // Request one frame, optionally dropping TxEn mid-frame; check when done arrives
  task automatic send(input int ch, input logic [7:0] b, input int drop_at, input int exp_done);
    int got;
    got = 0;
    txdat[ch] = b;
    txen[ch]  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 2) txdat[ch] = 8'($urandom);
      if (c == drop_at) begin
        txen[ch]  = 1'b0;
        txdat[ch] = 8'hFF;
      end
      if (done[ch]) begin
        got = c;
        break;
      end
    end
    check($sformatf("ch%0d send %02h done cycle", ch, b), 32'(got), 32'(exp_done));
    @(posedge clk);
    #1 txen[ch] = 1'b0;
  endtask

  task automatic run_random(input int ch, input int nfr);
    int drop;
    for (int f = 0; f < nfr; f++) begin
      repeat ($urandom_range(3, 8)) @(posedge clk);
      #1;
      if (f == 0)                     drop = 45;
      else if ($urandom_range(0, 1))  drop = $urandom_range(2, nbits(ch) * B);
      else                            drop = 0;
      send(ch, 8'($urandom), drop, done_cyc(ch));
    end
  endtask

  initial begin
    txen[0] = 1'b1; txen[1] = 1'b1; txen[2] = 1'b1;
    txdat[0] = 8'h55; txdat[1] = 8'h07; txdat[2] = 8'h07;

    repeat (5) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++)
        check($sformatf("ch%0d reset txd/done/busy", c),
              32'({txd[c], done[c], busy[c]}), 32'(3'b100));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      directed(0, 12'b001010101010, 101);
      directed(1, 12'b111000001110, 121);
      directed(2, 12'b010000001110, 111);
    join

    fork
      run_random(0, 10);
      run_random(1, 10);
      run_random(2, 10);
    join

    // Reset in the middle of data bit 4, with requests still pending
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      txdat[c] = 8'($urandom);
      txen[c]  = 1'b1;
    end
    @(posedge clk);
    repeat (55) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++)
      check($sformatf("ch%0d async reset txd/done", c), 32'({txd[c], done[c]}), 32'(2'b10));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      send(0, 8'hA5, 0, 101);
      send(1, 8'h3C, 0, 121);
      send(2, 8'hC3, 0, 111);
    join

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
